// File: rtl/fwd_pipe_tracker.sv
// Tracks destination registers through the EX/MEM and MEM/WB stages for forwarding,
// and detects load-use hazards with a two-state stall FSM and a saturating stall counter.
module fwd_pipe_tracker (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic        Flush,
    input  logic        IdExRegWrite,
    input  logic        IdExMemRead,
    input  logic [4:0]  IdExRd,
    input  logic [4:0]  IdExRs1,
    input  logic [4:0]  IdExRs2,
    input  logic [4:0]  IfIdRs1,
    input  logic [4:0]  IfIdRs2,
    output logic        ExMemRegWrite,
    output logic        MemWbRegWrite,
    output logic [4:0]  ExMemRd,
    output logic [4:0]  MemWbRd,
    output logic        ExMemRdNull,
    output logic        MemWbRdNull,
    output logic        ExMemRs1Equal,
    output logic        MemWbRs1Equal,
    output logic        ExMemRs2Equal,
    output logic        MemWbRs2Equal,
    output logic        LoadUseStall,
    output logic [15:0] StallCount
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ex_mem_regwrite;
    logic [4:0]  r_ex_mem_rd;
    logic        r_mem_wb_regwrite;
    logic [4:0]  r_mem_wb_rd;
    logic [15:0] r_stall_count;
    logic        w_hazard;
    logic        w_count_inc;

    // The load's MemRead flag has no consumer past EX, so only RegWrite/Rd are staged.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ex_mem_regwrite <= 1'b0;
            r_ex_mem_rd       <= 5'd0;
            r_mem_wb_regwrite <= 1'b0;
            r_mem_wb_rd       <= 5'd0;
        end else if (Enable) begin
            r_mem_wb_regwrite <= r_ex_mem_regwrite;
            r_mem_wb_rd       <= r_ex_mem_rd;
            if (Flush) begin
                r_ex_mem_regwrite <= 1'b0;
                r_ex_mem_rd       <= 5'd0;
            end else begin
                r_ex_mem_regwrite <= IdExRegWrite;
                r_ex_mem_rd       <= IdExRd;
            end
        end
    end

    always_comb begin
        w_hazard = IdExMemRead && (IdExRd != 5'd0) &&
                   ((IdExRd == IfIdRs1) || (IdExRd == IfIdRs2));
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_RUN;
        end else if (Enable) begin
            r_state <= w_state_nxt;
        end
    end

    // STALL always returns to RUN so one load never produces two stall cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_inc  = 1'b0;
        LoadUseStall = 1'b0;
        case (r_state)
            ST_RUN: begin
                LoadUseStall = w_hazard && !Flush;
                if (Flush) begin
                    w_state_nxt = ST_RUN;
                end else if (w_hazard) begin
                    w_state_nxt = ST_STALL;
                    w_count_inc = 1'b1;
                end
            end
            ST_STALL: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_stall_count <= 16'd0;
        end else if (Enable && w_count_inc && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign ExMemRegWrite = r_ex_mem_regwrite;
    assign MemWbRegWrite = r_mem_wb_regwrite;
    assign ExMemRd       = r_ex_mem_rd;
    assign MemWbRd       = r_mem_wb_rd;
    assign ExMemRdNull   = (r_ex_mem_rd != 5'd0);
    assign MemWbRdNull   = (r_mem_wb_rd != 5'd0);
    assign ExMemRs1Equal = (r_ex_mem_rd == IdExRs1);
    assign MemWbRs1Equal = (r_mem_wb_rd == IdExRs1);
    assign ExMemRs2Equal = (r_ex_mem_rd == IdExRs2);
    assign MemWbRs2Equal = (r_mem_wb_rd == IdExRs2);
    assign StallCount    = r_stall_count;

endmodule

// File: doc/fwd_pipe_tracker.md
FWD_PIPE_TRACKER -- requirements
Module: fwd_pipe_tracker

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-high reset, ports listed first: Clk input 1 (rising-edge clock); Rst input 1 (async, active-high reset).
REQ-002 The module SHALL have these inputs:
- Enable 1: pipeline advance; 0 = freeze.
- Flush 1: kill the instruction leaving ID/EX.
- IdExRegWrite 1: ID/EX instruction writes the register file.
- IdExMemRead 1: ID/EX instruction is a load.
- IdExRd 5: ID/EX destination register.
- IdExRs1, IdExRs2 5 each: EX-stage source registers.
- IfIdRs1, IfIdRs2 5 each: ID-stage source registers.
REQ-003 The module SHALL have these outputs:
- ExMemRegWrite, MemWbRegWrite 1 each: registered write flags.
- ExMemRd, MemWbRd 5 each: registered destination registers.
- ExMemRdNull, MemWbRdNull 1 each: 1 when that Rd is not x0.
- ExMemRs1Equal, MemWbRs1Equal, ExMemRs2Equal, MemWbRs2Equal 1 each: Rd equals IdExRs1 or IdExRs2.
- LoadUseStall 1: stall request to IF/ID and PC.
- StallCount 16: number of load-use stalls taken.

Function
REQ-004 On each rising Clk with Enable=1 and Flush=0, EX/MEM SHALL capture {IdExRegWrite, IdExMemRead, IdExRd}.
REQ-005 On each rising Clk with Enable=1 and Flush=1, EX/MEM SHALL capture a bubble {RegWrite=0, MemRead=0, Rd=0}.
REQ-006 On each rising Clk with Enable=1, MEM/WB SHALL capture the previous EX/MEM contents, giving exactly one cycle of latency per stage. Flush does not affect MEM/WB.
REQ-007 With Enable=0, all registers, the FSM state and StallCount SHALL hold their values.
REQ-008 The RdNull outputs SHALL be combinational from the registered Rd: 1 if and only if Rd != 5'd0.
REQ-009 Each Equal output SHALL be a combinational 5-bit equality between the registered Rd of its stage and the current IdExRs1 or IdExRs2. It is not qualified by RegWrite or RdNull; that qualification is done downstream.
REQ-010 The hazard condition H SHALL be IdExMemRead=1, IdExRd != 0, and (IdExRd == IfIdRs1 or IdExRd == IfIdRs2).
REQ-011 The FSM SHALL have two states, RUN and STALL.
REQ-012 In RUN: LoadUseStall = H (combinational). On an Enable=1 edge with H=1, the next state SHALL be STALL and StallCount SHALL increment by 1.
REQ-013 In STALL: LoadUseStall = 0. On the next Enable=1 edge the FSM SHALL return to RUN unconditionally. This prevents back-to-back double stalls on the same load.
REQ-014 Flush=1 SHALL force LoadUseStall=0 in that cycle, and the FSM SHALL go to RUN on that Enable=1 edge without incrementing StallCount.
REQ-015 StallCount SHALL saturate at 16'hFFFF; it does not wrap.
REQ-016 If Flush=1 and Enable=0 together, Flush SHALL be ignored and everything holds.
REQ-017 Rd=x0 writes SHALL propagate normally through EX/MEM and MEM/WB; only the RdNull outputs reflect them.

Reset
REQ-018 While Rst=1, asynchronously:
- All EX/MEM and MEM/WB fields SHALL be 0.
- State SHALL be RUN.
- StallCount SHALL be 0.
- Hence ExMemRegWrite, MemWbRegWrite, ExMemRd, MemWbRd and both RdNull outputs SHALL be 0.
REQ-019 Reset asserted mid-stall SHALL return the FSM to RUN immediately. After release, LoadUseStall SHALL follow H on the first cycle.

Verification
REQ-020 Pipe: IdExRegWrite=1, IdExRd=5, Enable=1 for 1 edge -> ExMemRd=5, ExMemRegWrite=1, ExMemRdNull=1. After the next edge -> MemWbRd=5, MemWbRegWrite=1.
REQ-021 Equal: ExMemRd=7, MemWbRd=7, IdExRs1=7, IdExRs2=3 -> ExMemRs1Equal=1, MemWbRs1Equal=1, both Rs2Equal=0. With Rd=0 and Rs1=0 -> Rs1Equal=1, RdNull=0.
REQ-022 Load-use: IdExMemRead=1, IdExRd=9, IfIdRs2=9 -> LoadUseStall=1. Next cycle (STALL), H still true -> LoadUseStall=0. StallCount=1. Following cycle RUN.
REQ-023 Flush/freeze:
- Flush=1 with IdExRegWrite=1, Rd=4 -> EX/MEM becomes a bubble (RegWrite=0, Rd=0), LoadUseStall=0.
- Enable=0 for 3 cycles -> all outputs unchanged.
REQ-024 Reset: assert Rst during STALL with StallCount=2 -> state RUN, StallCount=0, all registered outputs 0 without a clock edge.
REQ-025 Saturation: preload 65535 stalls (or force count) and trigger another hazard -> StallCount stays 16'hFFFF.
